// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with a
// one-cycle read latency. Reads pipeline at one access per cycle.
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = 0,
   parameter int MAX_RUN  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN);

   typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;

   master_e    last_grant;
   master_e    rd_owner;
   logic       rd_pend;
   logic [3:0] run;

   logic       req0, req1;
   logic       gnt_valid, gnt_write;
   master_e    gnt_sel;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = M0;
      if (!reset) begin
         gnt_valid = req0 | req1;
         if (req0 && req1) begin
            if (ARB_MODE == 0) begin
               if (last_grant == M1) gnt_sel = M0;
               else                  gnt_sel = M1;
            end else if (run == RUN_LIMIT) begin
               gnt_sel = M1;
            end
         end else if (req1) begin
            gnt_sel = M1;
         end
      end
   end

   // A simultaneous read+write is a write; the read half is dropped.
   assign gnt_write = gnt_valid & ((gnt_sel == M1) ? m1_write : m0_write);

   always_comb begin
      mem_chipselect = gnt_valid;
      mem_write      = gnt_write;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      if (gnt_valid) begin
         if (gnt_sel == M1) begin
            mem_address    = m1_address;
            mem_writedata  = m1_writedata;
            mem_byteenable = m1_write ? m1_byteenable : '1;
         end else begin
            mem_address    = m0_address;
            mem_writedata  = m0_writedata;
            mem_byteenable = m0_write ? m0_byteenable : '1;
         end
      end
   end

   assign m0_waitrequest = ~(gnt_valid && gnt_sel == M0);
   assign m1_waitrequest = ~(gnt_valid && gnt_sel == M1);
   assign mem_clken      = ~reset;

   // Read data is broadcast; only the owner's valid qualifies it. Reset kills an in-flight return.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pend & (rd_owner == M0) & ~reset;
   assign m1_readdatavalid = rd_pend & (rd_owner == M1) & ~reset;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= M1;
         run        <= '0;
         rd_pend    <= 1'b0;
         rd_owner   <= M0;
      end else begin
         if (gnt_valid) last_grant <= gnt_sel;
         rd_pend  <= gnt_valid & ~gnt_write;
         rd_owner <= gnt_sel;
         if (!req1 || (gnt_valid && gnt_sel == M1)) begin
            run <= '0;
         end else if (gnt_valid && run != RUN_LIMIT && run != 4'hF) begin
            run <= run + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: a round-robin instance backed by a RAM
// model plus a fixed-priority instance sharing the same master stimulus.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;

   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_readdata;

   logic        p_m0_waitrequest, p_m1_waitrequest, p_m0_readdatavalid, p_m1_readdatavalid;
   logic [31:0] p_m0_readdata, p_m1_readdata;
   logic [9:0]  p_mem_address;
   logic [3:0]  p_mem_byteenable;
   logic        p_mem_chipselect, p_mem_write, p_mem_clken;
   logic [31:0] p_mem_writedata;
   logic [31:0] p_mem_readdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(0), .MAX_RUN(4)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(1), .MAX_RUN(4)) dut_p (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(p_m0_waitrequest),
      .m0_readdata(p_m0_readdata), .m0_readdatavalid(p_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(p_m1_waitrequest),
      .m1_readdata(p_m1_readdata), .m1_readdatavalid(p_m1_readdatavalid),
      .mem_address(p_mem_address), .mem_byteenable(p_mem_byteenable),
      .mem_chipselect(p_mem_chipselect), .mem_write(p_mem_write),
      .mem_writedata(p_mem_writedata), .mem_clken(p_mem_clken), .mem_readdata(p_mem_readdata)
   );

   // RAM model: registered address, unregistered q; reloads a known pattern while clken is low.
   logic [31:0] ram [0:1023];
   logic [9:0]  ram_addr_q;
   always @(posedge clk) begin
      if (!mem_clken) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'h1000_0000 | 32'(i);
      end else begin
         if (mem_chipselect && mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         ram_addr_q <= mem_address;
      end
   end
   assign mem_readdata = ram[ram_addr_q];

   task automatic idle_inputs();
      m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1; idle_inputs(); m0_read = 1; m1_read = 1;
      #1;
      checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); end
      checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", mem_chipselect); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", mem_write); end
      checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b want 0", mem_clken); end
      checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
      checks++; if (p_mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_p_cs: got %b want 0", p_mem_chipselect); end
      @(negedge clk);
      reset = 0; idle_inputs();
      #1;
      checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL idle_clken: got %b want 1", mem_clken); end
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL idle_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
      checks++; if (mem_chipselect !== 1'b0 || mem_address !== 10'h000) begin errors++; $display("FAIL idle_mem: got cs=%b addr=%h want cs=0 addr=000", mem_chipselect, mem_address); end
   endtask

   task automatic test_single_read();
      @(negedge clk);
      idle_inputs(); m0_write = 1; m0_address = 10'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      #1;
      checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_wr_wait: got %b want 0", m0_waitrequest); end
      checks++; if (mem_write !== 1'b1 || mem_address !== 10'h005 || mem_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_wr_mem: got w=%b a=%h d=%h want w=1 a=005 d=deadbeef", mem_write, mem_address, mem_writedata); end
      @(negedge clk);
      idle_inputs(); m0_read = 1; m0_address = 10'h005;
      #1;
      checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_rd_wait: got %b want 0", m0_waitrequest); end
      checks++; if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_chipselect !== 1'b1) begin errors++; $display("FAIL sr_rd_mem: got w=%b be=%h cs=%b want w=0 be=f cs=1", mem_write, mem_byteenable, mem_chipselect); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sr_rdv: got %b want 1", m0_readdatavalid); end
      checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data: got %h want deadbeef", m0_readdata); end
      checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_m1_rdv: got %b want 0", m1_readdatavalid); end
      @(negedge clk);
      #1;
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_rdv_once: got %b want 0", m0_readdatavalid); end
   endtask

   // Both masters read continuously; a master advances its address only when accepted.
   task automatic test_round_robin();
      logic [9:0] exp_addr, prev_addr;
      @(negedge clk);
      reset = 1; idle_inputs();
      prev_addr = '0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         reset = 0; idle_inputs();
         if (k < 6) begin
            m0_read = 1; m0_address = 10'h010 + 10'((k + 1) / 2);
            m1_read = 1; m1_address = 10'h020 + 10'(k / 2);
         end
         #1;
         if (k < 6) begin
            exp_addr = (k % 2 == 0) ? 10'h010 + 10'(k / 2) : 10'h020 + 10'(k / 2);
            checks++; if (m0_waitrequest !== (k % 2 == 1)) begin errors++; $display("FAIL rr_m0_wait[%0d]: got %b want %b", k, m0_waitrequest, (k % 2 == 1)); end
            checks++; if (m1_waitrequest !== (k % 2 == 0)) begin errors++; $display("FAIL rr_m1_wait[%0d]: got %b want %b", k, m1_waitrequest, (k % 2 == 0)); end
            checks++; if (mem_chipselect !== 1'b1 || mem_address !== exp_addr) begin errors++; $display("FAIL rr_mem[%0d]: got cs=%b a=%h want cs=1 a=%h", k, mem_chipselect, mem_address, exp_addr); end
         end
         if (k > 0) begin
            checks++; if (m0_readdatavalid !== (k % 2 == 1) || m1_readdatavalid !== (k % 2 == 0)) begin errors++; $display("FAIL rr_rdv[%0d]: got %b%b want %b%b", k, m0_readdatavalid, m1_readdatavalid, (k % 2 == 1), (k % 2 == 0)); end
            checks++; if (m0_readdata !== (32'h1000_0000 | 32'(prev_addr))) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, m0_readdata, 32'h1000_0000 | 32'(prev_addr)); end
         end
         if (k < 6) prev_addr = exp_addr;
      end
   endtask

   // MAX_RUN=4: m0 x4, then m1 x1, repeating, on the fixed-priority instance.
   task automatic test_fixed_priority();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         idle_inputs(); m0_read = 1; m0_address = 10'h001; m1_read = 1; m1_address = 10'h002;
         #1;
         checks++; if (p_m1_waitrequest !== (k % 5 != 4)) begin errors++; $display("FAIL fp_m1_wait[%0d]: got %b want %b", k, p_m1_waitrequest, (k % 5 != 4)); end
         checks++; if (p_m0_waitrequest !== (k % 5 == 4)) begin errors++; $display("FAIL fp_m0_wait[%0d]: got %b want %b", k, p_m0_waitrequest, (k % 5 == 4)); end
         checks++; if (p_mem_chipselect !== 1'b1) begin errors++; $display("FAIL fp_cs[%0d]: got %b want 1", k, p_mem_chipselect); end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_byteenable();
      @(negedge clk);
      idle_inputs(); m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'hAABBCCDD; m1_byteenable = 4'hF;
      #1;
      checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL be_full_wait: got %b want 0", m1_waitrequest); end
      @(negedge clk);
      idle_inputs(); m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'h11223344; m1_byteenable = 4'b0101;
      #1;
      checks++; if (mem_byteenable !== 4'b0101 || mem_write !== 1'b1) begin errors++; $display("FAIL be_part: got be=%h w=%b want be=5 w=1", mem_byteenable, mem_write); end
      @(negedge clk);
      idle_inputs(); m1_read = 1; m1_address = 10'h3FF; m1_byteenable = 4'h0;
      #1;
      checks++; if (mem_byteenable !== 4'hF || mem_write !== 1'b0) begin errors++; $display("FAIL be_rd: got be=%h w=%b want be=f w=0", mem_byteenable, mem_write); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL be_rdv: got m1=%b m0=%b want m1=1 m0=0", m1_readdatavalid, m0_readdatavalid); end
      checks++; if (m1_readdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_data: got %h want aa22cc44", m1_readdata); end
   endtask

   task automatic test_read_write();
      @(negedge clk);
      idle_inputs(); m0_read = 1; m0_write = 1; m0_address = 10'h033; m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
      #1;
      checks++; if (mem_write !== 1'b1 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rw_write: got w=%b wait=%b want w=1 wait=0", mem_write, m0_waitrequest); end
      checks++; if (mem_writedata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_wdata: got %h want a5a5a5a5", mem_writedata); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv: got %b want 0", m0_readdatavalid); end
   endtask

   // A write issued in the cycle a read returns; both proceed together.
   task automatic test_back_to_back();
      @(negedge clk);
      idle_inputs(); m0_read = 1; m0_address = 10'h033;
      @(negedge clk);
      idle_inputs(); m1_write = 1; m1_address = 10'h055; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
      #1;
      checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rd: got v=%b d=%h want v=1 d=a5a5a5a5", m0_readdatavalid, m0_readdata); end
      checks++; if (mem_write !== 1'b1 || mem_address !== 10'h055 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wr: got w=%b a=%h wait=%b want w=1 a=055 wait=0", mem_write, mem_address, m1_waitrequest); end
      @(negedge clk);
      idle_inputs(); m1_read = 1; m1_address = 10'h055;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h12345678) begin errors++; $display("FAIL b2b_back: got v=%b d=%h want v=1 d=12345678", m1_readdatavalid, m1_readdata); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      idle_inputs(); m0_read = 1; m0_address = 10'h005;
      #1;
      checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL mr_accept: got %b want 0", m0_waitrequest); end
      @(negedge clk);
      reset = 1; idle_inputs(); m0_read = 1; m1_read = 1;
      #1;
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL mr_rdv: got %b want 0", m0_readdatavalid); end
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL mr_idle: got wait=%b cs=%b want wait=11 cs=0", {m0_waitrequest, m1_waitrequest}, mem_chipselect); end
      @(negedge clk);
      reset = 0; idle_inputs(); m0_read = 1; m1_read = 1; m0_address = 10'h007; m1_address = 10'h008;
      #1;
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL mr_first: got %b want 01", {m0_waitrequest, m1_waitrequest}); end
      checks++; if ({p_m0_waitrequest, p_m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL mr_p_first: got %b want 01", {p_m0_waitrequest, p_m1_waitrequest}); end
      @(negedge clk);
      #1;
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin errors++; $display("FAIL mr_second: got %b want 10", {m0_waitrequest, m1_waitrequest}); end
      checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1000_0007) begin errors++; $display("FAIL mr_data: got v=%b d=%h want v=1 d=10000007", m0_readdatavalid, m0_readdata); end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_byteenable();
      test_read_write();
      test_back_to_back();
      test_reset_mid_read();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
